// File: rtl/am29_scan_mux_pkg.sv
// ---------------------------------------------------------------------------
// am29_scan_mux_pkg
// Package shared by the am29 scan multiplexer and its select counter.
//   - pulls in clog2, MODE_STATIC / MODE_SCAN and the channel slice macro
//   - sel_act_e : which register update the select counter performs this edge
// ---------------------------------------------------------------------------
package am29_scan_mux_pkg;

`include "am29_mux_defs.vh"

    // Update chosen for the select/polarity registers on a non-reset edge.
    // Reset is handled directly in the register process and outranks all of these.
    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_LOAD = 2'd1,
        ACT_STEP = 2'd2
    } sel_act_e;

    localparam int NCH_MIN = 2;
    localparam int NCH_MAX = 64;

endpackage

// File: rtl/am29_mux_defs.vh
// ---------------------------------------------------------------------------
// am29_mux_defs.vh
// Shared definitions for the am29 scan multiplexer family.
//   - clog2       : constant function, ceil(log2(n)) for n >= 1
//   - MODE_STATIC : scan input level that leaves the select register static
//   - MODE_SCAN   : scan input level that lets step advance the select register
//   - AM29_CH_SLICE(vec, k, w) : channel k of a flat vector of w-bit channels
// Included once, inside am29_scan_mux_pkg; the design files pick the
// function and localparams up through the package import.
// ---------------------------------------------------------------------------
`ifndef AM29_MUX_DEFS_VH
`define AM29_MUX_DEFS_VH

`define AM29_CH_SLICE(vec, k, w) vec[(k)*(w) +: (w)]

localparam logic MODE_STATIC = 1'b0;
localparam logic MODE_SCAN   = 1'b1;

// Smallest r with 2**r >= n (n=1 gives 0).
function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
        r = r + 1;
        v = v >> 1;
    end
    return r;
endfunction

`endif

// File: rtl/am29_sel_counter.sv
// ---------------------------------------------------------------------------
// am29_sel_counter
// Select / polarity register with load, scan stepping and wrap detection.
//
// Parameters
//   SELW  select register width (ceil(log2(NCH)))
//   NCH   number of channels; select values >= NCH are "out of range"
//
// Ports
//   i_clk     in   1     rising-edge clock
//   i_rst     in   1     synchronous reset, active-high
//   i_load_n  in   1     active-low load of select and polarity
//   i_sel     in   SELW  select value to load
//   i_pol     in   1     polarity value to load
//   i_scan    in   1     MODE_SCAN lets i_step advance the select register
//   i_step    in   1     advance request (only honoured in scan mode)
//   o_sel_q   out  SELW  select register
//   o_pol_q   out  1     polarity register
//   o_wrap    out  1     one-cycle pulse after a step from NCH-1 to 0
//   o_ovr     out  1     select register holds a value >= NCH
//
// Update priority per edge: reset > load > (scan & step) > hold.
// ---------------------------------------------------------------------------
module am29_sel_counter
    import am29_scan_mux_pkg::*;
#(
    parameter int SELW = 3,
    parameter int NCH  = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load_n,
    input  logic [SELW-1:0] i_sel,
    input  logic            i_pol,
    input  logic            i_scan,
    input  logic            i_step,
    output logic [SELW-1:0] o_sel_q,
    output logic            o_pol_q,
    output logic            o_wrap,
    output logic            o_ovr
);

    // NCH is compared one bit wider than the register so that NCH = 2**SELW
    // (every code in range) is representable.
    localparam logic [SELW:0]   NCH_V = (SELW+1)'(NCH);
    localparam logic [SELW-1:0] LAST  = SELW'(NCH - 1);

    logic [SELW-1:0] r_sel_reg;
    logic            r_pol_reg;
    logic            r_wrap_reg;

    logic [SELW-1:0] w_sel_next;
    logic            w_pol_next;
    logic            w_wrap_next;
    logic            w_in_range;
    logic            w_at_last;
    sel_act_e        w_act;

    assign w_in_range = ({1'b0, r_sel_reg} < NCH_V);
    assign w_at_last  = (r_sel_reg == LAST);

    // Pick the update for this edge (reset is applied in the register process).
    always_comb begin
        w_act = ACT_HOLD;
        if (!i_load_n) begin
            w_act = ACT_LOAD;
        end else if ((i_scan == MODE_SCAN) && i_step) begin
            w_act = ACT_STEP;
        end
    end

    // Next-state values; wrap defaults low so it is a single-cycle pulse.
    always_comb begin
        w_sel_next  = r_sel_reg;
        w_pol_next  = r_pol_reg;
        w_wrap_next = 1'b0;
        case (w_act)
            ACT_LOAD: begin
                w_sel_next = i_sel;
                w_pol_next = i_pol;
            end
            ACT_STEP: begin
                if (!w_in_range) begin
                    // Out-of-range codes recover to channel 0 silently.
                    w_sel_next = '0;
                end else if (w_at_last) begin
                    w_sel_next  = '0;
                    w_wrap_next = 1'b1;
                end else begin
                    w_sel_next = r_sel_reg + SELW'(1);
                end
            end
            default: begin
                w_sel_next = r_sel_reg;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sel_reg  <= '0;
            r_pol_reg  <= 1'b0;
            r_wrap_reg <= 1'b0;
        end else begin
            r_sel_reg  <= w_sel_next;
            r_pol_reg  <= w_pol_next;
            r_wrap_reg <= w_wrap_next;
        end
    end

    assign o_sel_q = r_sel_reg;
    assign o_pol_q = r_pol_reg;
    assign o_wrap  = r_wrap_reg;
    assign o_ovr   = !w_in_range;

endmodule

// File: rtl/am29_scan_mux.sv
// ---------------------------------------------------------------------------
// am29_scan_mux
// NCH-channel, DW-bit data selector with a clocked select/polarity register,
// auto-scan sequencer, optional output register and tri-state outputs.
// Used on the condition-code / status path feeding a microprogram sequencer.
//
// Parameters
//   NCH      number of channels, 2..64 (any value, not only powers of two)
//   DW       bits per channel
//   SELW     select width, must equal ceil(log2(NCH))
//   REG_OUT  0: y follows the registers and d combinationally
//            1: y comes from an output register (one extra cycle)
//
// Ports
//   clk    in   1       rising-edge clock
//   rst    in   1       synchronous reset, active-high
//   d      in   NCH*DW  channel data, channel k = d[k*DW +: DW]
//   sel    in   SELW    select value, captured when load_=0
//   pol    in   1       polarity, captured with sel; 1 inverts y
//   load_  in   1       active-low load of sel/pol registers
//   scan   in   1       1 = scan mode, 0 = static
//   step   in   1       advance select by one (scan mode only)
//   oe_    in   1       active-low output enable for y and w_ (asynchronous)
//   y      out  DW      selected channel XOR polarity, 'z when oe_=1
//   w_     out  DW      ~y, 'z when oe_=1
//   sel_q  out  SELW    select register (always driven)
//   wrap   out  1       one-cycle pulse after a scan step from NCH-1 to 0
//   ovr    out  1       select register holds a value >= NCH
// ---------------------------------------------------------------------------
module am29_scan_mux
    import am29_scan_mux_pkg::*;
#(
    parameter int NCH     = 8,
    parameter int DW      = 1,
    parameter int SELW    = 3,
    parameter int REG_OUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*DW-1:0] d,
    input  logic [SELW-1:0]   sel,
    input  logic              pol,
    input  logic              load_,
    input  logic              scan,
    input  logic              step,
    input  logic              oe_,
    output logic [DW-1:0]     y,
    output logic [DW-1:0]     w_,
    output logic [SELW-1:0]   sel_q,
    output logic              wrap,
    output logic              ovr
);

    genvar gi;

    // Parameter sanity: refuse to elaborate an inconsistent select width.
    generate
        if ((SELW != clog2(NCH)) || (NCH < NCH_MIN) || (NCH > NCH_MAX)) begin : g_bad_param
            $error("am29_scan_mux: SELW must equal clog2(NCH) and NCH must be 2..64");
        end
    endgenerate

    logic [SELW-1:0] w_sel_q;
    logic            w_pol_q;
    logic            w_wrap;
    logic            w_ovr;

    am29_sel_counter #(
        .SELW (SELW),
        .NCH  (NCH)
    ) u_sel_counter (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_load_n (load_),
        .i_sel    (sel),
        .i_pol    (pol),
        .i_scan   (scan),
        .i_step   (step),
        .o_sel_q  (w_sel_q),
        .o_pol_q  (w_pol_q),
        .o_wrap   (w_wrap),
        .o_ovr    (w_ovr)
    );

    // Split the flat data bus into per-channel words.
    logic [DW-1:0] w_ch [NCH];

    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign w_ch[gi] = `AM29_CH_SLICE(d, gi, DW);
        end
    endgenerate

    // Only the selected word reaches y, so an unknown on any other channel
    // cannot leak through. An out-of-range select shows just the polarity.
    logic [DW-1:0] w_y_int;

    always_comb begin
        w_y_int = {DW{w_pol_q}};
        if (!w_ovr) begin
            w_y_int = w_ch[w_sel_q] ^ {DW{w_pol_q}};
        end
    end

    logic [DW-1:0] w_y_src;

    generate
        if (REG_OUT != 0) begin : g_out_reg
            logic [DW-1:0] r_y_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_y_reg <= '0;
                end else begin
                    r_y_reg <= w_y_int;
                end
            end

            assign w_y_src = r_y_reg;
        end else begin : g_out_comb
            assign w_y_src = w_y_int;
        end
    endgenerate

    // While reset is held the enabled outputs read y=0 / w_=all ones,
    // independent of what d carries on channel 0.
    logic [DW-1:0] w_y_drv;

    assign w_y_drv = rst ? '0 : w_y_src;

    // oe_ acts directly on the drivers; it is deliberately not registered.
    assign y  = oe_ ? {DW{1'bz}} : w_y_drv;
    assign w_ = oe_ ? {DW{1'bz}} : ~w_y_drv;

    assign sel_q = w_sel_q;
    assign wrap  = w_wrap;
    assign ovr   = w_ovr;

endmodule
